// File: rtl/fast_pkg.sv
// Shared types for the FAST adaptive threshold scheduler: FSM states,
// default widths and a bundle of the configuration fields.
package fast_pkg;

  localparam int FAST_THRESH_W = 8;
  localparam int FAST_CNT_W    = 16;
  localparam int FAST_STEP_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    ADJ,
    COMMIT
  } fast_thr_state_e;

  typedef struct packed {
    logic                     enable;
    logic [FAST_THRESH_W-1:0] thresh_init;
    logic [FAST_THRESH_W-1:0] thresh_min;
    logic [FAST_THRESH_W-1:0] thresh_max;
    logic [FAST_CNT_W-1:0]    target_cnt;
    logic [FAST_CNT_W-1:0]    hyst;
    logic [FAST_STEP_W-1:0]   step;
  } fast_thr_cfg_t;

endpackage

// File: rtl/fast_thr_adjust.sv
// Combinational next-threshold computation: compares a frame's corner count
// against target +/- hysteresis, steps the threshold and clamps it.
module fast_thr_adjust #(
  parameter int THRESH_WIDTH = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int STEP_WIDTH   = 4
) (
  input  logic [CNT_WIDTH-1:0]    cnt,
  input  logic [THRESH_WIDTH-1:0] threshold,
  input  logic [THRESH_WIDTH-1:0] thresh_min,
  input  logic [THRESH_WIDTH-1:0] thresh_max,
  input  logic [CNT_WIDTH-1:0]    target_cnt,
  input  logic [CNT_WIDTH-1:0]    hyst,
  input  logic [STEP_WIDTH-1:0]   step,
  output logic [THRESH_WIDTH-1:0] nxt
);

  localparam int TW1 = THRESH_WIDTH + 1;
  localparam int CW1 = CNT_WIDTH + 1;

  typedef logic [TW1-1:0] thr_ext_t;
  typedef logic [CW1-1:0] cnt_ext_t;

  function automatic thr_ext_t clamp_hi(input thr_ext_t v, input thr_ext_t hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic thr_ext_t clamp_lo(input thr_ext_t v, input thr_ext_t lo);
    return (v < lo) ? lo : v;
  endfunction

  cnt_ext_t cnt_x, tgt_x, tgt_hi, cnt_hi;
  thr_ext_t thr_x, step_x, min_x, max_x, thr_up, thr_dn, res;

  always_comb begin
    cnt_x  = cnt_ext_t'(cnt);
    tgt_x  = cnt_ext_t'(target_cnt);
    tgt_hi = tgt_x + cnt_ext_t'(hyst);
    cnt_hi = cnt_x + cnt_ext_t'(hyst);
    thr_x  = thr_ext_t'(threshold);
    step_x = thr_ext_t'(step);
    min_x  = thr_ext_t'(thresh_min);
    max_x  = thr_ext_t'(thresh_max);
    thr_up = thr_x + step_x;
    thr_dn = (thr_x > step_x) ? (thr_x - step_x) : '0;
    res    = thr_x;
    // The max clamp is applied last so it wins when min > max.
    if (cnt_x > tgt_hi) begin
      res = clamp_hi(thr_up, max_x);
    end else if (cnt_hi < tgt_x) begin
      res = clamp_hi(clamp_lo(thr_dn, min_x), max_x);
    end
    nxt = res[THRESH_WIDTH-1:0];
  end

endmodule

// File: rtl/fast_thresh_ctrl.sv
// Adaptive FAST threshold scheduler: holds the threshold for a frame, counts
// reported corners and steps the threshold toward the corner budget at frame end.
module fast_thresh_ctrl
  import fast_pkg::*;
#(
  parameter int THRESH_WIDTH = FAST_THRESH_W,
  parameter int CNT_WIDTH    = FAST_CNT_W,
  parameter int STEP_WIDTH   = FAST_STEP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_enable,
  input  logic [THRESH_WIDTH-1:0] cfg_thresh_init,
  input  logic [THRESH_WIDTH-1:0] cfg_thresh_min,
  input  logic [THRESH_WIDTH-1:0] cfg_thresh_max,
  input  logic [CNT_WIDTH-1:0]    cfg_target_cnt,
  input  logic [CNT_WIDTH-1:0]    cfg_hyst,
  input  logic [STEP_WIDTH-1:0]   cfg_step,
  input  logic                    frame_start,
  input  logic                    frame_end,
  input  logic                    corner_valid,
  output logic [THRESH_WIDTH-1:0] threshold,
  output logic                    thresh_update,
  output logic [CNT_WIDTH-1:0]    frame_corner_cnt,
  output logic                    stat_valid,
  output logic                    busy,
  output logic                    err_trunc
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [THRESH_WIDTH-1:0] clamp_thr(
    input logic [THRESH_WIDTH-1:0] v,
    input logic [THRESH_WIDTH-1:0] lo,
    input logic [THRESH_WIDTH-1:0] hi
  );
    logic [THRESH_WIDTH-1:0] t;
    t = (v < lo) ? lo : v;
    return (t > hi) ? hi : t;
  endfunction

  fast_thr_state_e         state, state_nxt;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    pend_start;
  logic [THRESH_WIDTH-1:0] nxt_thr;

  fast_thr_adjust #(
    .THRESH_WIDTH (THRESH_WIDTH),
    .CNT_WIDTH    (CNT_WIDTH),
    .STEP_WIDTH   (STEP_WIDTH)
  ) u_adjust (
    .cnt        (cnt),
    .threshold  (threshold),
    .thresh_min (cfg_thresh_min),
    .thresh_max (cfg_thresh_max),
    .target_cnt (cfg_target_cnt),
    .hyst       (cfg_hyst),
    .step       (cfg_step),
    .nxt        (nxt_thr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (cfg_enable) state_nxt = ARMED;
      ARMED: begin
        if (frame_start)      state_nxt = RUN;
        else if (!cfg_enable) state_nxt = IDLE;
      end
      RUN:    if (frame_end) state_nxt = ADJ;
      ADJ:    state_nxt = COMMIT;
      COMMIT: begin
        if (!cfg_enable)                     state_nxt = IDLE;
        else if (pend_start || frame_start)  state_nxt = RUN;
        else                                 state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == ADJ) || (state == COMMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      threshold        <= '0;
      cnt              <= '0;
      frame_corner_cnt <= '0;
      thresh_update    <= 1'b0;
      stat_valid       <= 1'b0;
      err_trunc        <= 1'b0;
      pend_start       <= 1'b0;
    end else begin
      thresh_update <= 1'b0;
      stat_valid    <= 1'b0;
      unique case (state)
        IDLE:  threshold <= clamp_thr(cfg_thresh_init, cfg_thresh_min, cfg_thresh_max);
        ARMED: if (frame_start) cnt <= '0;
        RUN: begin
          // A restart without frame_end discards the partial frame.
          if (frame_start && !frame_end) begin
            cnt       <= corner_valid ? CNT_WIDTH'(1) : '0;
            err_trunc <= 1'b1;
          end else if (corner_valid) begin
            cnt <= sat_inc(cnt);
          end
          // Stats are published as ADJ is entered so they appear one cycle after frame_end.
          if (frame_end) begin
            frame_corner_cnt <= corner_valid ? sat_inc(cnt) : cnt;
            stat_valid       <= 1'b1;
            pend_start       <= frame_start;
          end
        end
        ADJ: begin
          threshold     <= nxt_thr;
          thresh_update <= (nxt_thr != threshold);
          if (frame_start) pend_start <= 1'b1;
        end
        COMMIT: begin
          pend_start <= 1'b0;
          if (state_nxt == RUN) cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_thresh_ctrl.sv
// Self-checking bench for fast_thresh_ctrl: table-driven frames with a
// scoreboard of expected stats/threshold, plus hand-written corner sequences.
module tb_fast_thresh_ctrl;
  import fast_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [7:0]  cfg_thresh_init, cfg_thresh_min, cfg_thresh_max;
  logic [15:0] cfg_target_cnt, cfg_hyst;
  logic [3:0]  cfg_step;
  logic        frame_start, frame_end, corner_valid;
  logic [7:0]  threshold;
  logic        thresh_update;
  logic [15:0] frame_corner_cnt;
  logic        stat_valid, busy, err_trunc;

  always #5 clk = ~clk;

  fast_thresh_ctrl #(.THRESH_WIDTH(8), .CNT_WIDTH(16), .STEP_WIDTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_enable       (cfg_enable),
    .cfg_thresh_init  (cfg_thresh_init),
    .cfg_thresh_min   (cfg_thresh_min),
    .cfg_thresh_max   (cfg_thresh_max),
    .cfg_target_cnt   (cfg_target_cnt),
    .cfg_hyst         (cfg_hyst),
    .cfg_step         (cfg_step),
    .frame_start      (frame_start),
    .frame_end        (frame_end),
    .corner_valid     (corner_valid),
    .threshold        (threshold),
    .thresh_update    (thresh_update),
    .frame_corner_cnt (frame_corner_cnt),
    .stat_valid       (stat_valid),
    .busy             (busy),
    .err_trunc        (err_trunc)
  );

  typedef struct {
    int cnt;
    int thr;
    bit upd;
  } exp_t;

  typedef struct {
    bit            rst_first;
    fast_thr_cfg_t cfg;
    int            ncorn;
    bit            coinc;
    exp_t          e;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  bit   chk_next;
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic fast_thr_cfg_t mk_cfg(input int init, input int mn, input int mx,
                                           input int tgt, input int hy, input int st);
    fast_thr_cfg_t c;
    c.enable      = 1'b1;
    c.thresh_init = 8'(init);
    c.thresh_min  = 8'(mn);
    c.thresh_max  = 8'(mx);
    c.target_cnt  = 16'(tgt);
    c.hyst        = 16'(hy);
    c.step        = 4'(st);
    return c;
  endfunction

  function automatic vec_t mk_vec(input bit rf, input fast_thr_cfg_t c, input int n, input bit co,
                                  input int ec, input int et, input bit eu);
    vec_t v;
    v.rst_first = rf;
    v.cfg       = c;
    v.ncorn     = n;
    v.coinc     = co;
    v.e.cnt     = ec;
    v.e.thr     = et;
    v.e.upd     = eu;
    return v;
  endfunction

  task automatic apply_cfg(input fast_thr_cfg_t c);
    cfg_enable      = c.enable;
    cfg_thresh_init = c.thresh_init;
    cfg_thresh_min  = c.thresh_min;
    cfg_thresh_max  = c.thresh_max;
    cfg_target_cnt  = c.target_cnt;
    cfg_hyst        = c.hyst;
    cfg_step        = c.step;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    cfg_enable   = 1'b0;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    corner_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic corners(input int n);
    for (int i = 0; i < n; i++) begin
      corner_valid = 1'b1;
      tick();
    end
    corner_valid = 1'b0;
  endtask

  task automatic end_frame(input bit coinc, input exp_t e);
    sb.push_back(e);
    frame_end    = 1'b1;
    corner_valid = coinc;
    tick();
    frame_end    = 1'b0;
    corner_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // Scoreboard monitor: stat_valid pops an expectation, the following cycle
  // must show the committed threshold and matching thresh_update.
  initial begin
    chk_next = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_next) begin
        check("thr_commit", threshold, cur.thr);
        check("thresh_update", thresh_update, cur.upd);
        chk_next = 1'b0;
      end else if (thresh_update === 1'b1) begin
        failures++;
        $display("FAIL spurious_thresh_update: got 1 expected 0");
      end
      if (stat_valid === 1'b1) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_stat_valid: got 1 expected 0");
        end else begin
          cur = sb.pop_front();
          check("frame_corner_cnt", frame_corner_cnt, cur.cnt);
          chk_next = 1'b1;
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: timeout reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fast_thr_cfg_t cfg_a;
    exp_t          e;
    cfg_a = mk_cfg(20, 5, 60, 100, 10, 4);

    // Reset state.
    apply_cfg(cfg_a);
    do_reset();
    rst = 1'b1;
    cfg_enable = 1'b0;
    tick();
    check("rst_threshold", threshold, 0);
    check("rst_thresh_update", thresh_update, 0);
    check("rst_frame_corner_cnt", frame_corner_cnt, 0);
    check("rst_stat_valid", stat_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_trunc", err_trunc, 0);
    rst = 1'b0;

    // IDLE clamping of the init threshold, including min > max.
    cfg_thresh_init = 8'd200;
    tick();
    tick();
    check("idle_clamp_max", threshold, 60);
    check("idle_busy", busy, 0);
    cfg_thresh_init = 8'd1;
    tick();
    check("idle_clamp_min", threshold, 5);
    cfg_thresh_min  = 8'd70;
    cfg_thresh_init = 8'd65;
    tick();
    check("idle_min_gt_max", threshold, 60);

    // Frame table.
    vecs.push_back(mk_vec(1, cfg_a, 150, 0, 150, 24, 1));
    vecs.push_back(mk_vec(1, cfg_a, 50, 0, 50, 16, 1));
    vecs.push_back(mk_vec(0, cfg_a, 105, 0, 105, 16, 0));
    vecs.push_back(mk_vec(0, cfg_a, 99, 1, 100, 16, 0));
    vecs.push_back(mk_vec(1, mk_cfg(58, 5, 60, 100, 10, 4), 500, 0, 500, 60, 1));
    vecs.push_back(mk_vec(0, mk_cfg(58, 5, 60, 100, 10, 4), 500, 0, 500, 60, 0));
    vecs.push_back(mk_vec(1, mk_cfg(2, 0, 60, 100, 10, 4), 0, 0, 0, 0, 1));
    vecs.push_back(mk_vec(0, mk_cfg(2, 0, 60, 100, 10, 4), 0, 0, 0, 0, 0));
    vecs.push_back(mk_vec(1, cfg_a, 110, 0, 110, 20, 0));
    vecs.push_back(mk_vec(0, cfg_a, 111, 0, 111, 24, 1));
    vecs.push_back(mk_vec(0, cfg_a, 90, 0, 90, 24, 0));
    vecs.push_back(mk_vec(0, cfg_a, 89, 0, 89, 20, 1));
    vecs.push_back(mk_vec(0, cfg_a, 70000, 0, 65535, 24, 1));

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) begin
        do_reset();
        apply_cfg(vecs[i].cfg);
        tick();
        check("arm_threshold", threshold, 32'(vecs[i].cfg.thresh_init));
      end
      start_pulse();
      check("run_busy", busy, 1);
      corners(vecs[i].ncorn);
      end_frame(vecs[i].coinc, vecs[i].e);
    end

    // frame_start during COMMIT: next frame follows without a lost frame.
    do_reset();
    apply_cfg(cfg_a);
    tick();
    start_pulse();
    corners(150);
    e = '{cnt: 150, thr: 24, upd: 1'b1};
    sb.push_back(e);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("commit_restart_busy", busy, 1);
    corners(50);
    end_frame(1'b0, '{cnt: 50, thr: 20, upd: 1'b1});
    check("commit_restart_no_err", err_trunc, 0);

    // cfg_enable dropped mid-RUN: frame completes, adjusts, then IDLE.
    start_pulse();
    corners(150);
    cfg_enable = 1'b0;
    end_frame(1'b0, '{cnt: 150, thr: 24, upd: 1'b1});
    check("disable_idle_busy", busy, 0);
    tick();
    check("disable_idle_thr", threshold, 20);

    // Restart mid-RUN: truncation flagged, count restarts, threshold held.
    do_reset();
    apply_cfg(cfg_a);
    tick();
    start_pulse();
    corners(30);
    frame_start  = 1'b1;
    corner_valid = 1'b1;
    tick();
    frame_start  = 1'b0;
    corner_valid = 1'b0;
    check("trunc_err", err_trunc, 1);
    check("trunc_thr_held", threshold, 20);
    check("trunc_busy", busy, 1);
    corners(49);
    end_frame(1'b0, '{cnt: 50, thr: 16, upd: 1'b1});
    check("trunc_err_sticky", err_trunc, 1);

    // Reset mid-RUN, then re-enable.
    start_pulse();
    corners(10);
    rst = 1'b1;
    tick();
    check("midrst_threshold", threshold, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err_trunc", err_trunc, 0);
    rst = 1'b0;
    tick();
    check("reenable_threshold", threshold, 16'(cfg_thresh_init));

    tick();
    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
